switch_mcu_id_type_r: RTL

SWITCH_MCU_ID_TYPE_R -- requirements
Module: switch_mcu_id_type_r

---
 rtl/switch_mcu_pkg.sv | 29 ++
 rtl/switch_mcu_rtype_dec.sv | 29 ++
 rtl/switch_mcu_id_type_r.sv | 97 +++++++++
 3 files changed

// File: rtl/switch_mcu_pkg.sv
// Shared constants for the R-type instruction-decode slice: opcode/funct fields,
// FSM state encoding, op-vector bit positions and the default execution length.
package switch_mcu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    localparam int EXEC_CYCLES_DEFAULT = 5;

    // Bit positions inside the one-hot op vector.
    localparam int OP_ADD  = 4;
    localparam int OP_SUB  = 3;
    localparam int OP_SLL  = 2;
    localparam int OP_SLT  = 1;
    localparam int OP_SLTU = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/switch_mcu_rtype_dec.sv
// Combinational R-type decoder: maps an RV32 word onto a one-hot op vector
// covering add/sub/sll/slt/sltu; anything else is reported as not legal.
module switch_mcu_rtype_dec
    import switch_mcu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  op,
    output logic        legal
);

    logic unused_fields;
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        op = '0;
        if (instr[6:0] == OPC_OP) begin
            case ({instr[31:25], instr[14:12]})
                {F7_BASE, F3_ADD_SUB}: op[OP_ADD]  = 1'b1;
                {F7_ALT,  F3_ADD_SUB}: op[OP_SUB]  = 1'b1;
                {F7_BASE, F3_SLL}:     op[OP_SLL]  = 1'b1;
                {F7_BASE, F3_SLT}:     op[OP_SLT]  = 1'b1;
                {F7_BASE, F3_SLTU}:    op[OP_SLTU] = 1'b1;
                default:               op = '0;
            endcase
        end
        legal = |op;
    end

endmodule

// File: rtl/switch_mcu_id_type_r.sv
// R-type issue stage: accepts one instruction at a time, holds its op strobes
// and register fields for EXEC_CYCLES phases, then pulses out_done.
module switch_mcu_id_type_r
    import switch_mcu_pkg::*;
#(
    parameter int EXEC_CYCLES = EXEC_CYCLES_DEFAULT
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_instr_valid,
    input  logic [31:0] in_instr,
    output logic        out_instr_ready,
    input  logic        in_stall,
    input  logic        in_flush,
    output logic        out_en,
    output logic        out_add,
    output logic        out_sub,
    output logic        out_sll,
    output logic        out_slt,
    output logic        out_sltu,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [3:0]  out_cycle_cnt,
    output logic        out_done,
    output logic        out_illegal,
    output logic [7:0]  out_illegal_cnt
);

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    logic [0:0] state;
    logic [4:0] op_dec;
    logic       legal_dec;
    logic [4:0] op_q;
    logic       handshake;

    assign out_instr_ready = (state == ST_IDLE) && !in_flush;
    assign handshake       = in_instr_valid && out_instr_ready;

    switch_mcu_rtype_dec u_dec (
        .instr (in_instr),
        .op    (op_dec),
        .legal (legal_dec)
    );

    assign out_add  = op_q[OP_ADD];
    assign out_sub  = op_q[OP_SUB];
    assign out_sll  = op_q[OP_SLL];
    assign out_slt  = op_q[OP_SLT];
    assign out_sltu = op_q[OP_SLTU];

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state           <= ST_IDLE;
            out_en          <= 1'b0;
            op_q            <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_rd          <= '0;
            out_cycle_cnt   <= '0;
            out_done        <= 1'b0;
            out_illegal     <= 1'b0;
            out_illegal_cnt <= '0;
        end else begin
            out_done    <= 1'b0;
            out_illegal <= 1'b0;
            if (state == ST_IDLE) begin
                if (handshake && legal_dec) begin
                    state         <= ST_EXEC;
                    out_en        <= 1'b1;
                    op_q          <= op_dec;
                    out_rs1       <= in_instr[19:15];
                    out_rs2       <= in_instr[24:20];
                    out_rd        <= in_instr[11:7];
                    out_cycle_cnt <= '0;
                end else if (handshake) begin
                    out_illegal     <= 1'b1;
                    out_illegal_cnt <= sat_inc8(out_illegal_cnt);
                end
            end else if (in_flush || (!in_stall && out_cycle_cnt == LAST_CNT)) begin
                // Flush and normal completion share the clear path; only completion reports done.
                state         <= ST_IDLE;
                out_en        <= 1'b0;
                op_q          <= '0;
                out_rs1       <= '0;
                out_rs2       <= '0;
                out_rd        <= '0;
                out_cycle_cnt <= '0;
                out_done      <= !in_flush;
            end else if (!in_stall) begin
                out_cycle_cnt <= out_cycle_cnt + 4'd1;
            end
        end
    end

endmodule
